// File: rtl/wash_pkg.sv
// wash_pkg
// Shared definitions for the washing-machine controller and its phase timer.
//   phase_e  : controller phase codes as reported on state_dbg (3 bits)
//   tstate_e : phase-timer states IDLE / RUN / EXPIRED
//   is_timed : true for the phases that carry a duration (WASH, RINSE, SPIN)
package wash_pkg;

  typedef enum logic [2:0] {
    CHECK_DOOR    = 3'd0,
    ADD_WATER     = 3'd1,
    ADD_DETERGENT = 3'd2,
    WASH          = 3'd3,
    RINSE         = 3'd4,
    SPIN          = 3'd5
  } phase_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } tstate_e;

  // Codes 6 and 7 are illegal and deliberately fall into the untimed group.
  function automatic logic is_timed(input logic [2:0] code);
    logic timed;
    case (code)
      WASH, RINSE, SPIN: timed = 1'b1;
      default:           timed = 1'b0;
    endcase
    return timed;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Divides the system clock into a one-cycle tick every CLK_DIV enabled cycles.
// The count only advances while enable is high, so a paused timer keeps its
// partial tick instead of losing it.
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset
//   clear  : synchronous restart of the count from 0 (wins over enable)
//   enable : advance the count this cycle
//   tick   : high in the enabled cycle whose edge completes a period
module tick_prescaler #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = enable && (cnt_q == LAST);

  // Wraps to 0 on the tick edge so the next period starts cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      if (cnt_q == LAST) cnt_q <= '0;
      else               cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/wash_phase_timer.sv
// wash_phase_timer
// Produces the wash/rinse/spin timeout inputs of the washing-machine
// controller. On entry to a timed phase the per-phase duration is loaded and
// counted down on a prescaled tick; the matching timeout is held high while
// the controller stays in that phase.
//   clk, reset      : clock and asynchronous active-high reset
//   state_dbg       : controller phase code (see wash_pkg::phase_e)
//   pause           : freezes prescaler and countdown
//   *_timeout       : duration of the current phase has expired
//   remaining       : ticks left in the current timed phase
//   busy            : countdown in progress
// Optional build macro WASH_TIMER_LOAD_EN adds cfg_we/cfg_sel/cfg_data for
// run-time programmable durations; without it the parameters are used.
module wash_phase_timer
  import wash_pkg::*;
#(
  parameter int CLK_DIV     = 1000,
  parameter int CNT_W       = 16,
  parameter int WASH_TICKS  = 300,
  parameter int RINSE_TICKS = 120,
  parameter int SPIN_TICKS  = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       state_dbg,
  input  logic             pause,
  output logic             wash_timeout,
  output logic             rinse_timeout,
  output logic             spin_timeout,
  output logic [CNT_W-1:0] remaining,
  output logic             busy
`ifdef WASH_TIMER_LOAD_EN
  ,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data
`endif
);

  localparam logic [CNT_W-1:0] WASH_D  = CNT_W'(WASH_TICKS);
  localparam logic [CNT_W-1:0] RINSE_D = CNT_W'(RINSE_TICKS);
  localparam logic [CNT_W-1:0] SPIN_D  = CNT_W'(SPIN_TICKS);

  logic [2:0]       phase_q;
  tstate_e          tstate_q;
  logic [CNT_W-1:0] remaining_q;
  logic             phase_change;
  logic             tick;
  logic [CNT_W-1:0] wash_dur, rinse_dur, spin_dur;
  logic [CNT_W-1:0] load_val;

  assign phase_change = (state_dbg != phase_q);

`ifdef WASH_TIMER_LOAD_EN
  logic [CNT_W-1:0] wash_dur_q, rinse_dur_q, spin_dur_q;

  // A write landing on a load edge is not seen by that load because the
  // load reads the register value from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wash_dur_q  <= WASH_D;
      rinse_dur_q <= RINSE_D;
      spin_dur_q  <= SPIN_D;
    end else if (cfg_we) begin
      case (cfg_sel)
        2'd0:    wash_dur_q  <= cfg_data;
        2'd1:    rinse_dur_q <= cfg_data;
        2'd2:    spin_dur_q  <= cfg_data;
        default: ;
      endcase
    end
  end

  assign wash_dur  = wash_dur_q;
  assign rinse_dur = rinse_dur_q;
  assign spin_dur  = spin_dur_q;
`else
  assign wash_dur  = WASH_D;
  assign rinse_dur = RINSE_D;
  assign spin_dur  = SPIN_D;
`endif

  always_comb begin
    load_val = '0;
    case (state_dbg)
      WASH:    load_val = wash_dur;
      RINSE:   load_val = rinse_dur;
      SPIN:    load_val = spin_dur;
      default: load_val = '0;
    endcase
  end

  // The prescaler restarts on every phase change and only runs in RUN.
  tick_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (phase_change),
    .enable((tstate_q == RUN) && !pause && !phase_change),
    .tick  (tick)
  );

  // Timer FSM: a phase change always wins; otherwise RUN counts down and
  // EXPIRED/IDLE hold. The <=1 test keeps the counter from wrapping at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q     <= 3'd0;
      tstate_q    <= IDLE;
      remaining_q <= '0;
    end else begin
      phase_q <= state_dbg;
      if (phase_change) begin
        if (is_timed(state_dbg)) begin
          remaining_q <= load_val;
          tstate_q    <= (load_val == '0) ? EXPIRED : RUN;
        end else begin
          remaining_q <= '0;
          tstate_q    <= IDLE;
        end
      end else if ((tstate_q == RUN) && tick) begin
        if (remaining_q <= CNT_W'(1)) begin
          remaining_q <= '0;
          tstate_q    <= EXPIRED;
        end else begin
          remaining_q <= remaining_q - CNT_W'(1);
        end
      end
    end
  end

  // Qualifying with the live state_dbg drops the timeout in the same cycle
  // the controller leaves, so it cannot leak into the next phase.
  assign wash_timeout  = (tstate_q == EXPIRED) && (phase_q == WASH)  && (state_dbg == WASH);
  assign rinse_timeout = (tstate_q == EXPIRED) && (phase_q == RINSE) && (state_dbg == RINSE);
  assign spin_timeout  = (tstate_q == EXPIRED) && (phase_q == SPIN)  && (state_dbg == SPIN);
  assign remaining     = remaining_q;
  assign busy          = (tstate_q == RUN);

endmodule

// File: tb/tb_wash_phase_timer.sv
// tb_wash_phase_timer
// Directed bench for wash_phase_timer with CLK_DIV=4, WASH=3, RINSE=2, SPIN=0.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_wash_phase_timer;

  logic        clk;
  logic        reset;
  logic [2:0]  state_dbg;
  logic        pause;
  logic        wash_timeout;
  logic        rinse_timeout;
  logic        spin_timeout;
  logic [15:0] remaining;
  logic        busy;
`ifdef WASH_TIMER_LOAD_EN
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_data;
`endif

  int tests;
  int fails;

  wash_phase_timer #(
    .CLK_DIV    (4),
    .CNT_W      (16),
    .WASH_TICKS (3),
    .RINSE_TICKS(2),
    .SPIN_TICKS (0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .state_dbg    (state_dbg),
    .pause        (pause),
    .wash_timeout (wash_timeout),
    .rinse_timeout(rinse_timeout),
    .spin_timeout (spin_timeout),
    .remaining    (remaining),
    .busy         (busy)
`ifdef WASH_TIMER_LOAD_EN
    ,
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_data     (cfg_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    tests++;
    if ({remaining, busy, wash_timeout, rinse_timeout, spin_timeout} !== 20'd0) begin
      fails++;
      $display("[TB] FAIL reset_state got rem=%0d busy=%b to=%b%b%b want all 0",
               remaining, busy, wash_timeout, rinse_timeout, spin_timeout);
    end
    step();
    step();
    tests++;
    if ({remaining, busy} !== 17'd0) begin
      fails++;
      $display("[TB] FAIL reset_held got rem=%0d busy=%b want 0 0", remaining, busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_wash();
    logic [15:0] exp_rem;
    state_dbg = 3'd3;
    step();
    tests++;
    if (remaining !== 16'd3 || busy !== 1'b1 || wash_timeout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL wash_load got rem=%0d busy=%b to=%b want 3 1 0",
               remaining, busy, wash_timeout);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_rem = 16'(3 - k / 4);
      tests++;
      if (remaining !== exp_rem || wash_timeout !== (k == 12) || busy !== (k != 12)) begin
        fails++;
        $display("[TB] FAIL wash_count k=%0d got rem=%0d to=%b busy=%b want %0d %b %b",
                 k, remaining, wash_timeout, busy, exp_rem, (k == 12), (k != 12));
      end
    end
  endtask

  task automatic test_back_to_back();
    state_dbg = 3'd4;
    #1;
    tests++;
    if (wash_timeout !== 1'b0 || rinse_timeout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_drop got wash=%b rinse=%b want 0 0", wash_timeout, rinse_timeout);
    end
    step();
    tests++;
    if (remaining !== 16'd2 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rinse_load got rem=%0d busy=%b want 2 1", remaining, busy);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      tests++;
      if (rinse_timeout !== (k == 8)) begin
        fails++;
        $display("[TB] FAIL rinse_timeout k=%0d got %b want %b", k, rinse_timeout, (k == 8));
      end
    end
  endtask

  task automatic test_spin_zero();
    state_dbg = 3'd5;
    #1;
    tests++;
    if (rinse_timeout !== 1'b0 || spin_timeout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL spin_stale got rinse=%b spin=%b want 0 0", rinse_timeout, spin_timeout);
    end
    step();
    tests++;
    if (spin_timeout !== 1'b1 || busy !== 1'b0 || remaining !== 16'd0) begin
      fails++;
      $display("[TB] FAIL spin_zero got to=%b busy=%b rem=%0d want 1 0 0",
               spin_timeout, busy, remaining);
    end
    state_dbg = 3'd0;
    #1;
    tests++;
    if (spin_timeout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL spin_leave got %b want 0", spin_timeout);
    end
    step();
    tests++;
    if (busy !== 1'b0 || remaining !== 16'd0 || spin_timeout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL spin_idle got busy=%b rem=%0d to=%b want 0 0 0",
               busy, remaining, spin_timeout);
    end
    state_dbg = 3'd5;
    step();
    tests++;
    if (spin_timeout !== 1'b1) begin
      fails++;
      $display("[TB] FAIL spin_reentry got %b want 1", spin_timeout);
    end
    state_dbg = 3'd1;
    step();
  endtask

  task automatic test_pause();
    logic [15:0] exp_rem;
    state_dbg = 3'd3;
    step();
    step();
    step();
    pause = 1'b1;
    for (int k = 3; k <= 12; k++) begin
      step();
      tests++;
      if (remaining !== 16'd3 || wash_timeout !== 1'b0) begin
        fails++;
        $display("[TB] FAIL pause_hold k=%0d got rem=%0d to=%b want 3 0", k, remaining, wash_timeout);
      end
    end
    pause = 1'b0;
    for (int k = 13; k <= 22; k++) begin
      step();
      exp_rem = 16'(3 - (k - 10) / 4);
      tests++;
      if (remaining !== exp_rem || wash_timeout !== (k == 22)) begin
        fails++;
        $display("[TB] FAIL pause_resume k=%0d got rem=%0d to=%b want %0d %b",
                 k, remaining, wash_timeout, exp_rem, (k == 22));
      end
    end
  endtask

  task automatic test_reset_mid();
    state_dbg = 3'd0;
    step();
    state_dbg = 3'd3;
    step();
    repeat (6) step();
    tests++;
    if (remaining !== 16'd2) begin
      fails++;
      $display("[TB] FAIL mid_pre got rem=%0d want 2", remaining);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (remaining !== 16'd0 || busy !== 1'b0 || wash_timeout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_async got rem=%0d busy=%b to=%b want 0 0 0",
               remaining, busy, wash_timeout);
    end
    step();
    reset = 1'b0;
    step();
    tests++;
    if (remaining !== 16'd3 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_reload got rem=%0d busy=%b want 3 1", remaining, busy);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      tests++;
      if (wash_timeout !== (k == 12)) begin
        fails++;
        $display("[TB] FAIL mid_fresh k=%0d got %b want %b", k, wash_timeout, (k == 12));
      end
    end
  endtask

  task automatic test_illegal();
    state_dbg = 3'd6;
    #1;
    tests++;
    if (wash_timeout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL illegal_drop got %b want 0", wash_timeout);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      tests++;
      if ({busy, wash_timeout, rinse_timeout, spin_timeout} !== 4'd0 || remaining !== 16'd0) begin
        fails++;
        $display("[TB] FAIL illegal_idle k=%0d got busy=%b to=%b%b%b rem=%0d want all 0",
                 k, busy, wash_timeout, rinse_timeout, spin_timeout, remaining);
      end
    end
  endtask

`ifdef WASH_TIMER_LOAD_EN
  task automatic test_cfg_load();
    state_dbg = 3'd4;
    step();
    cfg_we   = 1'b1;
    cfg_sel  = 2'd0;
    cfg_data = 16'd5;
    step();
    cfg_we = 1'b0;
    tests++;
    if (remaining !== 16'd2) begin
      fails++;
      $display("[TB] FAIL cfg_rinse got rem=%0d want 2", remaining);
    end
    state_dbg = 3'd3;
    step();
    tests++;
    if (remaining !== 16'd5) begin
      fails++;
      $display("[TB] FAIL cfg_load got rem=%0d want 5", remaining);
    end
    for (int k = 1; k <= 20; k++) begin
      step();
      tests++;
      if (wash_timeout !== (k == 20)) begin
        fails++;
        $display("[TB] FAIL cfg_timeout k=%0d got %b want %b", k, wash_timeout, (k == 20));
      end
    end
    state_dbg = 3'd6;
    step();
    tests++;
    if ({busy, wash_timeout, rinse_timeout, spin_timeout} !== 4'd0) begin
      fails++;
      $display("[TB] FAIL cfg_illegal got busy=%b to=%b%b%b want 0",
               busy, wash_timeout, rinse_timeout, spin_timeout);
    end
  endtask
`endif

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b0;
    state_dbg = 3'd0;
    pause     = 1'b0;
`ifdef WASH_TIMER_LOAD_EN
    cfg_we    = 1'b0;
    cfg_sel   = 2'd0;
    cfg_data  = 16'd0;
`endif
    #1;
    test_reset();
    test_wash();
    test_back_to_back();
    test_spin_zero();
    test_pause();
    test_reset_mid();
    test_illegal();
`ifdef WASH_TIMER_LOAD_EN
    test_cfg_load();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
